// File: rtl/sample_frame_collector.sv
// Serial-to-parallel frame collector: gathers N complex samples into ping-pong banks
// and presents each completed frame as a parallel array. Optional macro: FRAME_SYNC_EN.
package sample_frame_collector_pkg;
  localparam int unsigned CP_W = 16;

  typedef struct packed {
    logic signed [CP_W-1:0] re;
    logic signed [CP_W-1:0] im;
  } complex_product_t;
endpackage

module sample_frame_collector
  import sample_frame_collector_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  complex_product_t        in_data,
`ifdef FRAME_SYNC_EN
  input  logic                    in_sof,
  output logic                    sync_err,
`endif
  output complex_product_t [N-1:0] output_array,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        frame_count
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] r_wr_idx;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [1:0]       r_full;
  logic [CNT_W-1:0] r_frame_count;
  complex_product_t r_bank [2][N];

  logic             w_accept;
  logic             w_handoff;
  logic             w_sof;
  logic             w_last;
  logic [IDX_W-1:0] w_wr_addr;
  logic [1:0]       w_full_nxt;

  // Handshakes and next full flags; a handoff and a frame completion always hit different banks.
  always_comb begin
    w_accept   = in_valid & in_ready;
    w_handoff  = out_valid & out_ready;
`ifdef FRAME_SYNC_EN
    w_sof      = in_sof;
`else
    w_sof      = 1'b0;
`endif
    w_last     = ~w_sof & (r_wr_idx == IDX_W'(N - 1));
    w_wr_addr  = w_sof ? '0 : r_wr_idx;
    w_full_nxt = r_full;
    if (w_accept && w_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_handoff)          w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Control state: pointers, flags and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_idx      <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_full        <= 2'b00;
      r_frame_count <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        if (w_sof) begin
          r_wr_idx <= IDX_W'(1);
        end else if (w_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
      end
      if (w_handoff) begin
        r_rd_bank     <= ~r_rd_bank;
        r_frame_count <= r_frame_count + CNT_W'(1);
      end
    end
  end

`ifdef FRAME_SYNC_EN
  logic r_sync_err;

  // Sticky flag: a start-of-frame arrived while a partial frame was in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_err <= 1'b0;
    end else if (w_accept && w_sof && (r_wr_idx != '0)) begin
      r_sync_err <= 1'b1;
    end
  end

  assign sync_err = r_sync_err;
`endif

  // Sample storage needs no reset; a full bank is never written.
  always_ff @(posedge clk) begin
    if (w_accept) r_bank[r_wr_bank][w_wr_addr] <= in_data;
  end

  assign in_ready    = ~r_full[r_wr_bank];
  assign out_valid   = r_full[r_rd_bank];
  assign frame_count = r_frame_count;

  // Frame is shown only while valid so reset yields an all-zero array immediately.
  always_comb begin
    output_array = '0;
    if (out_valid) begin
      for (int k = 0; k < int'(N); k++) output_array[k] = r_bank[r_rd_bank][k];
    end
  end

endmodule

// File: tb/tb_sample_frame_collector.sv
// Randomized self-checking bench for sample_frame_collector against a queue-based frame model.
module tb_sample_frame_collector;
  import sample_frame_collector_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 16;

  typedef complex_product_t [N-1:0] frame_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  complex_product_t in_data;
  frame_t           output_array;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] frame_count;
`ifdef FRAME_SYNC_EN
  logic             in_sof;
  logic             sync_err;
  bit               m_err;
`endif

  int n_checks;
  int n_fail;

  complex_product_t m_cur[$];
  frame_t           m_pend[$];
  logic [CNT_W-1:0] m_cnt;

  sample_frame_collector #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
`ifdef FRAME_SYNC_EN
    .in_sof       (in_sof),
    .sync_err     (sync_err),
`endif
    .output_array (output_array),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  function automatic complex_product_t mk(input int k);
    complex_product_t c;
    c.re = 16'(k);
    c.im = 16'(0 - k);
    return c;
  endfunction

  function automatic frame_t m_front();
    frame_t f;
    f = '0;
    if (m_pend.size() > 0) f = m_pend[0];
    return f;
  endfunction

  function automatic bit m_ready();
    return m_pend.size() < 2;
  endfunction

  function automatic bit m_valid();
    return m_pend.size() > 0;
  endfunction

  task automatic model_reset();
    m_cur.delete();
    m_pend.delete();
    m_cnt = '0;
`ifdef FRAME_SYNC_EN
    m_err = 1'b0;
`endif
  endtask

  task automatic drive(input bit v, input complex_product_t d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef FRAME_SYNC_EN
    in_sof    = 1'b0;
`endif
  endtask

  // Apply one clock edge to the model (using the current inputs), then to the DUT.
  task automatic tick();
    bit acc, hand, sof_now;
    frame_t f;
    acc  = in_valid && m_ready();
    hand = m_valid() && out_ready;
`ifdef FRAME_SYNC_EN
    sof_now = in_sof;
`else
    sof_now = 1'b0;
`endif
    if (hand) begin
      void'(m_pend.pop_front());
      m_cnt = m_cnt + CNT_W'(1);
    end
    if (acc) begin
      if (sof_now) begin
`ifdef FRAME_SYNC_EN
        if (m_cur.size() != 0) m_err = 1'b1;
`endif
        m_cur.delete();
        m_cur.push_back(in_data);
      end else begin
        m_cur.push_back(in_data);
        if (m_cur.size() == N) begin
          for (int i = 0; i < int'(N); i++) f[i] = m_cur[i];
          m_pend.push_back(f);
          m_cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (frame_count !== '0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_checks++; if (output_array !== '0) begin n_fail++; $display("FAIL reset_output_array: got %h want 0", output_array); end
  endtask

  task automatic test_single_frame();
    for (int k = 0; k < int'(N); k++) begin
      drive(1'b1, mk(k), 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid k=%0d: got %b want 0", k, out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready k=%0d: got %b want 1", k, in_ready); end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_latency: got %b want 1", out_valid); end
    for (int k = 0; k < int'(N); k++) begin
      n_checks++; if (output_array[k] !== mk(k)) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", k, output_array[k], mk(k)); end
    end
    tick();
    n_checks++; if (frame_count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_frame_count: got %0d want 1", frame_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] start;
    int g;
    start = m_cnt;
    for (int k = 0; k < 3 * int'(N); k++) begin
      drive(1'b1, mk(k), 1'b1);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready k=%0d: got %b want 1", k, in_ready); end
      n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL b2b_out_valid k=%0d: got %b want %b", k, out_valid, m_valid()); end
      if (m_valid()) begin
        n_checks++; if (output_array !== m_front()) begin n_fail++; $display("FAIL b2b_data k=%0d: got %h want %h", k, output_array, m_front()); end
      end
      tick();
    end
    g = 0;
    while (m_valid() && g < 4) begin
      drive(1'b0, '0, 1'b1);
      n_checks++; if (output_array !== m_front()) begin n_fail++; $display("FAIL b2b_tail_data: got %h want %h", output_array, m_front()); end
      tick();
      g++;
    end
    n_checks++; if (frame_count !== start + CNT_W'(3)) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want %0d", frame_count, start + CNT_W'(3)); end
  endtask

  task automatic flush();
    int g;
    g = 0;
    while ((m_valid() || m_cur.size() > 0) && g < 60) begin
      drive(m_cur.size() > 0, complex_product_t'(32'($urandom)), 1'b1);
      n_checks++; if (out_valid !== m_valid() || in_ready !== m_ready()) begin n_fail++; $display("FAIL flush_flags: got v=%b r=%b want v=%b r=%b", out_valid, in_ready, m_valid(), m_ready()); end
      tick();
      g++;
    end
    n_checks++; if (g >= 60) begin n_fail++; $display("FAIL flush_timeout: got %0d cycles want < 60", g); end
  endtask

  task automatic test_backpressure();
    int idx, g;
    idx = 0;
    g = 0;
    while (idx < 2 * int'(N) && g < 40) begin
      drive(1'b1, mk(100 + idx), 1'b0);
      n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL bp_fill_ready idx=%0d: got %b want %b", idx, in_ready, m_ready()); end
      if (m_ready()) idx++;
      tick();
      g++;
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, mk(100 + idx), 1'b0);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready c=%0d: got %b want 0", c, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid c=%0d: got %b want 1", c, out_valid); end
      n_checks++; if (output_array[0] !== mk(100) || output_array[N-1] !== mk(107)) begin n_fail++; $display("FAIL bp_stable c=%0d: got %h want frame 100..107", c, output_array); end
      tick();
    end
    drive(1'b1, mk(100 + idx), 1'b1);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_handoff_ready: got %b want 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_freed_ready: got %b want 1", in_ready); end
    while (idx < 20 && g < 60) begin
      drive(1'b1, mk(100 + idx), 1'b0);
      n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL bp_refill_ready idx=%0d: got %b want %b", idx, in_ready, m_ready()); end
      if (m_ready()) idx++;
      tick();
      g++;
    end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (output_array[0] !== mk(108) || output_array !== m_front()) begin n_fail++; $display("FAIL bp_second_frame: got %h want %h", output_array, m_front()); end
    n_checks++; if (m_cur.size() != 4 || m_cur[0] !== mk(116)) begin n_fail++; $display("FAIL bp_partial_model: got %0d samples want 4 from 116", m_cur.size()); end
    flush();
  endtask

  task automatic test_gap();
    int k;
    k = 0;
    for (int c = 0; c < int'(N) + 5; c++) begin
      if (c >= 4 && c < 9) drive(1'b0, '0, 1'b1);
      else begin drive(1'b1, mk(200 + k), 1'b1); k++; end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid c=%0d: got %b want 0", c, out_valid); end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", out_valid); end
    for (int i = 0; i < int'(N); i++) begin
      n_checks++; if (output_array[i] !== mk(200 + i)) begin n_fail++; $display("FAIL gap_data[%0d]: got %h want %h", i, output_array[i], mk(200 + i)); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < int'(N) + 5; k++) begin
      drive(1'b1, mk(300 + k), 1'b0);
      tick();
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b want 1", out_valid); end
    n_checks++; if (frame_count === '0) begin n_fail++; $display("FAIL rmid_precount: got 0 want nonzero"); end
    drive(1'b0, '0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    n_checks++; if (frame_count !== '0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", frame_count); end
    n_checks++; if (output_array !== '0) begin n_fail++; $display("FAIL rmid_array: got %h want 0", output_array); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      drive(1'b1, mk(50 + k), 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_clean_early k=%0d: got %b want 0", k, out_valid); end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < int'(N); i++) begin
      n_checks++; if (output_array[i] !== mk(50 + i)) begin n_fail++; $display("FAIL rmid_clean_data[%0d]: got %h want %h", i, output_array[i], mk(50 + i)); end
    end
    tick();
    n_checks++; if (frame_count !== CNT_W'(1)) begin n_fail++; $display("FAIL rmid_clean_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, complex_product_t'(32'($urandom)), ($urandom % 3) != 0);
      n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, m_ready()); end
      n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, m_valid()); end
      n_checks++; if (output_array !== m_front()) begin n_fail++; $display("FAIL rand_data c=%0d: got %h want %h", c, output_array, m_front()); end
      n_checks++; if (frame_count !== m_cnt) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, frame_count, m_cnt); end
      tick();
    end
    flush();
  endtask

`ifdef FRAME_SYNC_EN
  task automatic test_sync();
    for (int k = 0; k < 3; k++) begin drive(1'b1, mk(90 + k), 1'b0); tick(); end
    for (int k = 0; k < int'(N); k++) begin
      drive(1'b1, mk(100 + k), 1'b0);
      in_sof = (k == 0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sync_valid: got %b want 1", out_valid); end
    n_checks++; if (output_array !== m_front() || output_array[0] !== mk(100)) begin n_fail++; $display("FAIL sync_data: got %h want %h", output_array, m_front()); end
    n_checks++; if (sync_err !== m_err) begin n_fail++; $display("FAIL sync_err_set: got %b want %b", sync_err, m_err); end
    for (int k = 0; k < int'(N); k++) begin
      drive(1'b1, mk(400 + k), 1'b1);
      in_sof = (k == 0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (output_array !== m_front() || output_array[N-1] !== mk(407)) begin n_fail++; $display("FAIL sync_aligned_data: got %h want %h", output_array, m_front()); end
    n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_sticky: got %b want 1", sync_err); end
    tick();
    flush();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, '0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_random();
`ifdef FRAME_SYNC_EN
    test_sync();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_frame_collector.md
Name: sample_frame_collector

Overview:
- Serial-to-parallel front end for the FFT datapath.
- Accepts one complex_product_t sample per cycle on a valid/ready stream and assembles N consecutive samples into one frame.
- Presents each completed frame as a parallel N-wide array with a valid/ready handshake.
- Its output array drives the bit-reversal reorder stage input directly; its out_valid gates that stage's enable.
- Ping-pong (two-bank) buffering lets collection of frame k+1 overlap consumption of frame k.

Parameters:
- N, 8, samples per frame; power of two, minimum 2.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; all state cleared while low.
- in_valid  input  1  in_data carries a valid sample.
- in_ready  output  1  collector can accept a sample this cycle.
- in_data  input  complex_product_t  serial input sample.
- output_array  output  complex_product_t [N-1:0]  completed frame; sample k of the frame is at index k.
- out_valid  output  1  output_array holds a complete frame.
- out_ready  input  1  downstream consumes the frame this cycle.
- frame_count  output  CNT_W  number of frames handed off (out_valid & out_ready); wraps modulo 2^CNT_W.

Behaviour:
- Storage: two banks, each N x complex_product_t.
  - wr_bank pointer, rd_bank pointer, full[1:0] flags.
  - Write index wr_idx of width $clog2(N).
- Reset (reset low, asynchronous):
  - wr_idx=0, wr_bank=0, rd_bank=0, full=2'b00, frame_count=0.
  - out_valid=0, output_array all '0.
  - Bank contents need not be cleared.
  - Assertion mid-frame discards the partial frame and any pending frames.
- in_ready = ~full[wr_bank]. It is a registered-state function only, with no combinational path from out_ready.
- Sample accept (in_valid & in_ready):
  - bank[wr_bank][wr_idx] <= in_data, and wr_idx increments.
  - When wr_idx==N-1: wr_idx wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- Output handshake:
  - out_valid = full[rd_bank]; output_array = bank[rd_bank], driven from registers.
  - Latency: out_valid rises the cycle after the Nth sample of a frame is accepted.
  - On out_valid & out_ready: full[rd_bank] <= 0, rd_bank toggles, frame_count increments.
  - While out_valid & ~out_ready, output_array and out_valid must hold stable.
- Simultaneous events:
  - If a handoff and the completion of a write to the other bank occur in the same cycle, both flag updates apply.
  - out_valid stays high next cycle, showing the newly filled bank.
- Backpressure:
  - With both banks full, in_ready=0.
  - After a handoff frees a bank, in_ready returns high on the following cycle.
- Throughput: with out_ready held high, one sample per cycle is sustained indefinitely with no bubbles.
- Ordering: frames leave in arrival order; samples inside a frame are never reordered. Bit reversal is the downstream stage's job.
- Overflow is impossible by construction: a full bank is never written.

Optional Feature:
- Macro: FRAME_SYNC_EN.
- Defined:
  - Adds input in_sof (1 bit) and output sync_err (1 bit, sticky, reset 0).
  - An accepted sample with in_sof=1 is always written to index 0 of the current write bank, and wr_idx becomes 1.
  - If wr_idx!=0 at that moment, the partial frame is abandoned (no full flag set) and sync_err is set to 1.
  - sync_err clears only on reset.
- Not defined: no in_sof or sync_err ports; frames are delimited purely by counting N accepted samples.

Test Plan (N=8):
1. Reset release, drive in_data=k for k=0..7 on consecutive cycles, out_ready=1 -> out_valid high exactly 1 cycle after k=7 accepted, output_array[k]=k, frame_count=1.
2. Stream 24 samples back-to-back, out_ready=1 -> three frames {0..7},{8..15},{16..23}, in_ready never low, frame_count=3.
3. out_ready=0, stream 20 samples -> in_ready drops after sample 15. Frame 0 holds stable. Raise out_ready for one cycle -> frame 0 handed off, in_ready high next cycle, samples 16..19 land in the freed bank.
4. Gap in in_valid mid-frame (samples 0..3, 5 idle cycles, samples 4..7) -> single correct frame, out_valid only after sample 7.
5. Assert reset low after 5 samples with one frame pending -> out_valid=0, frame_count=0, output_array=0 immediately. Next 8 samples form a clean frame.
6. FRAME_SYNC_EN: 3 samples, then in_sof with value 100 followed by 101..107 -> frame {100..107}, sync_err=1. A second aligned frame leaves sync_err at 1.
